// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache memory-side blocks: default widths
// and the memory-bus state encoding.
package dcache_pkg;

    localparam int DCACHE_DATABITS = 32;
    localparam int DCACHE_ADDRBITS = 32;

    localparam logic [1:0] BUS_IDLE  = 2'd0;
    localparam logic [1:0] BUS_WRITE = 2'd1;
    localparam logic [1:0] BUS_READ  = 2'd2;
    localparam logic [1:0] BUS_RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = BUS_IDLE,
        ST_WRITE = BUS_WRITE,
        ST_READ  = BUS_READ,
        ST_RESP  = BUS_RESP
    } bus_state_t;

endpackage

// File: rtl/dcache_wfifo.sv
// Posted-write FIFO: RAM array with wrap-bit pointers and a registered head
// that already shows the next entry in the cycle after a pop.
module dcache_wfifo #(
    parameter int WIDTH = 62,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             one_left,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      wr_ptr_next, rd_ptr_next;
    logic [AW:0]      level;
    logic             push_ok, pop_ok, bypass;
    logic [WIDTH-1:0] ram [DEPTH];
    logic [WIDTH-1:0] head_reg;

    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign level    = wr_ptr_reg - rd_ptr_reg;
    assign one_left = (level == PTR_ONE);

    // A push is judged against the pre-pop state, so push+pop at full drops the push.
    assign push_ok     = push && !full;
    assign pop_ok      = pop && !empty;
    assign wr_ptr_next = push_ok ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
    assign rd_ptr_next = pop_ok  ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;

    // The word being written lands at the new head when the FIFO drains to it.
    assign bypass = push_ok && (wr_ptr_reg == rd_ptr_next);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            ram[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            head_reg   <= bypass ? push_data : ram[rd_ptr_next[AW-1:0]];
        end
    end

    assign head = head_reg;

endmodule

// File: rtl/dcache_mem_bridge.sv
// Data-cache to single-beat memory bus bridge: posted writes drain through a
// FIFO, and reads are only issued once every earlier write has been acked.
module dcache_mem_bridge
    import dcache_pkg::*;
#(
    parameter int DATABITS  = DCACHE_DATABITS,
    parameter int ADDRBITS  = DCACHE_ADDRBITS,
    parameter int FIFODEPTH = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDRBITS-1:0] mem_addr,
    input  logic [DATABITS-1:0] mem_in,
    input  logic                mem_rdreq,
    input  logic                mem_wrreq,
    output logic [DATABITS-1:0] mem_out,
    output logic                mem_out_valid,
    output logic [15:0]         mem_burstlen,
    output logic [ADDRBITS-1:0] bus_addr,
    output logic [DATABITS-1:0] bus_wdata,
    output logic                bus_we,
    output logic                bus_req,
    input  logic                bus_ack,
    input  logic [DATABITS-1:0] bus_rdata,
    output logic                err_overflow,
    output logic                err_collision
);

    localparam int WADDR     = ADDRBITS - 2;
    localparam int ENTRYBITS = WADDR + DATABITS;

    bus_state_t           state_reg, state_next;
    logic [WADDR-1:0]     rd_addr_reg;
    logic [DATABITS-1:0]  mem_out_reg;
    logic                 err_overflow_reg, err_collision_reg;
    logic                 fifo_full, fifo_empty, fifo_one_left, fifo_pop;
    logic [ENTRYBITS-1:0] fifo_head;
    logic [WADDR-1:0]     head_addr;
    logic [DATABITS-1:0]  head_data;
    logic                 unused_addr_lsbs;

    // Byte-offset bits never reach the bus.
    assign unused_addr_lsbs = ^mem_addr[1:0];

    assign fifo_pop = (state_reg == ST_WRITE) && bus_ack;

    dcache_wfifo #(
        .WIDTH (ENTRYBITS),
        .DEPTH (FIFODEPTH)
    ) u_wfifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (mem_wrreq),
        .push_data ({mem_addr[ADDRBITS-1:2], mem_in}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .one_left  (fifo_one_left),
        .head      (fifo_head)
    );

    assign {head_addr, head_data} = fifo_head;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                // Going straight to WRITE on the push lets the beat start next cycle.
                if (!fifo_empty || mem_wrreq) begin
                    state_next = ST_WRITE;
                end else if (mem_rdreq) begin
                    state_next = ST_READ;
                end
            end
            ST_WRITE: begin
                // A word pushed in the same cycle keeps the stream going without a bubble.
                if (bus_ack && fifo_one_left && !mem_wrreq) begin
                    state_next = ST_IDLE;
                end
            end
            ST_READ: begin
                if (bus_ack) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= ST_IDLE;
            rd_addr_reg       <= '0;
            mem_out_reg       <= '0;
            err_overflow_reg  <= 1'b0;
            err_collision_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && state_next == ST_READ) begin
                rd_addr_reg <= mem_addr[ADDRBITS-1:2];
            end
            if (state_reg == ST_READ && bus_ack) begin
                mem_out_reg <= bus_rdata;
            end
            if (mem_wrreq && fifo_full) begin
                err_overflow_reg <= 1'b1;
            end
            if (mem_wrreq && mem_rdreq) begin
                err_collision_reg <= 1'b1;
            end
        end
    end

    // Bus outputs decode straight from registered state, so they cannot move mid-beat.
    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state_reg)
            ST_WRITE: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = {head_addr, 2'b00};
                bus_wdata = head_data;
            end
            ST_READ: begin
                bus_req  = 1'b1;
                bus_addr = {rd_addr_reg, 2'b00};
            end
            default: begin
                bus_req = 1'b0;
            end
        endcase
    end

    assign mem_out       = mem_out_reg;
    assign mem_out_valid = (state_reg == ST_RESP);
    assign mem_burstlen  = 16'(FIFODEPTH);
    assign err_overflow  = err_overflow_reg;
    assign err_collision = err_collision_reg;

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Directed bench for dcache_mem_bridge: a vector table of writes/reads against
// a bus memory model, plus hand sequences for bursts, overflow, latency, reset.
module tb_dcache_mem_bridge;

    logic        clk;
    logic        reset_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_in;
    logic        mem_rdreq;
    logic        mem_wrreq;
    logic [31:0] mem_out;
    logic        mem_out_valid;
    logic [15:0] mem_burstlen;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_req;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        err_overflow;
    logic        err_collision;

    dcache_mem_bridge #(
        .DATABITS  (32),
        .ADDRBITS  (32),
        .FIFODEPTH (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_addr      (mem_addr),
        .mem_in        (mem_in),
        .mem_rdreq     (mem_rdreq),
        .mem_wrreq     (mem_wrreq),
        .mem_out       (mem_out),
        .mem_out_valid (mem_out_valid),
        .mem_burstlen  (mem_burstlen),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_we        (bus_we),
        .bus_req       (bus_req),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .err_overflow  (err_overflow),
        .err_collision (err_collision)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    beat_t       beats[$];
    logic [31:0] mem_model [logic [31:0]];
    int          ack_delay;
    bit          ack_hold;
    int          checks;
    int          errors;

    // Bus slave: acks after ack_delay wait cycles, logs every completed beat.
    initial begin
        int wait_cnt;
        logic [31:0] rd;
        wait_cnt  = 0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus_req && reset_n) begin
                if (!ack_hold && wait_cnt >= ack_delay) begin
                    bus_ack  = 1'b1;
                    wait_cnt = 0;
                    if (bus_we) begin
                        mem_model[bus_addr] = bus_wdata;
                        beats.push_back('{1'b1, bus_addr, bus_wdata});
                    end else begin
                        rd = mem_model.exists(bus_addr) ? mem_model[bus_addr]
                                                        : (bus_addr ^ 32'hA5A5_A5A5);
                        bus_rdata = rd;
                        beats.push_back('{1'b0, bus_addr, rd});
                    end
                end else begin
                    bus_ack  = 1'b0;
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                bus_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_beats(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (beats.size() >= target) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (beats.size() >= target) ok = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output bit ok, output int cycles);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < limit; i++) begin
            step();
            cycles = cycles + 1;
            if (mem_out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    vec_t vecs[10];

    initial begin
        bit ok;
        int cyc;
        int nb;

        checks    = 0;
        errors    = 0;
        ack_delay = 0;
        ack_hold  = 1'b0;
        reset_n   = 1'b0;
        mem_addr  = '0;
        mem_in    = '0;
        mem_rdreq = 1'b0;
        mem_wrreq = 1'b0;

        vecs[0] = '{1'b1, 32'h0000_0200, 32'h1111_1111, 32'h0000_0200, 32'h1111_1111};
        vecs[1] = '{1'b1, 32'h0000_0206, 32'h2222_2222, 32'h0000_0204, 32'h2222_2222};
        vecs[2] = '{1'b0, 32'h0000_0200, 32'h0,         32'h0000_0200, 32'h1111_1111};
        vecs[3] = '{1'b0, 32'h0000_0207, 32'h0,         32'h0000_0204, 32'h2222_2222};
        vecs[4] = '{1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'h0000_0200, 32'hCAFE_F00D};
        vecs[5] = '{1'b0, 32'h0000_0201, 32'h0,         32'h0000_0200, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 32'h0000_0300, 32'h0,         32'h0000_0300, 32'hA5A5_A6A5};
        vecs[7] = '{1'b1, 32'h0000_0104, 32'h55AA_55AA, 32'h0000_0104, 32'h55AA_55AA};
        vecs[8] = '{1'b0, 32'h0000_0104, 32'h0,         32'h0000_0104, 32'h55AA_55AA};
        vecs[9] = '{1'b0, 32'h0000_0100, 32'h0,         32'h0000_0100, 32'hDEAD_BEEF};

        // Reset state
        step();
        step();
        check("rst bus_req", {31'd0, bus_req}, 32'd0);
        check("rst bus_addr", bus_addr, 32'd0);
        check("rst mem_out", mem_out, 32'd0);
        check("rst mem_out_valid", {31'd0, mem_out_valid}, 32'd0);
        check("rst err_overflow", {31'd0, err_overflow}, 32'd0);
        check("rst err_collision", {31'd0, err_collision}, 32'd0);
        check("rst mem_burstlen", {16'd0, mem_burstlen}, 32'd8);
        reset_n = 1'b1;
        step();

        // Single write: beat must be on the bus the very next cycle
        nb        = beats.size();
        mem_wrreq = 1'b1;
        mem_addr  = 32'h0000_0100;
        mem_in    = 32'hDEAD_BEEF;
        step();
        mem_wrreq = 1'b0;
        check("single bus_req", {31'd0, bus_req}, 32'd1);
        check("single bus_we", {31'd0, bus_we}, 32'd1);
        check("single bus_addr", bus_addr, 32'h0000_0100);
        check("single bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        step();
        check("single beat count", beats.size() - nb, 32'd1);
        check("single bus_req drop", {31'd0, bus_req}, 32'd0);

        // Vector table against the memory model
        ack_delay = 1;
        foreach (vecs[i]) begin
            nb = beats.size();
            if (vecs[i].is_wr) begin
                mem_wrreq = 1'b1;
                mem_addr  = vecs[i].addr;
                mem_in    = vecs[i].data;
                step();
                mem_wrreq = 1'b0;
                wait_beats(nb + 1, 20, ok);
                check($sformatf("vec%0d wr done", i), {31'd0, ok}, 32'd1);
                if (ok) begin
                    check($sformatf("vec%0d wr addr", i), beats[nb].addr, vecs[i].exp_addr);
                    check($sformatf("vec%0d wr data", i), beats[nb].data, vecs[i].exp_data);
                end
            end else begin
                mem_rdreq = 1'b1;
                mem_addr  = vecs[i].addr;
                wait_valid(20, ok, cyc);
                mem_rdreq = 1'b0;
                check($sformatf("vec%0d rd valid", i), {31'd0, ok}, 32'd1);
                check($sformatf("vec%0d rd data", i), mem_out, vecs[i].exp_data);
                if (beats.size() > nb) begin
                    check($sformatf("vec%0d rd addr", i), beats[nb].addr, vecs[i].exp_addr);
                end
            end
        end

        // Burst of 8 with an ack every third cycle
        step();
        ack_delay = 2;
        nb        = beats.size();
        for (int i = 0; i < 8; i++) begin
            mem_wrreq = 1'b1;
            mem_addr  = 32'(i * 4);
            mem_in    = 32'hA000_0000 + 32'(i);
            step();
        end
        mem_wrreq = 1'b0;
        wait_beats(nb + 8, 100, ok);
        check("burst complete", {31'd0, ok}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (beats.size() > nb + i) begin
                check($sformatf("burst%0d addr", i), beats[nb + i].addr, 32'(i * 4));
                check($sformatf("burst%0d data", i), beats[nb + i].data, 32'hA000_0000 + 32'(i));
            end
        end
        check("burst err_overflow", {31'd0, err_overflow}, 32'd0);

        // Overflow: nine writes with the bus stalled
        step();
        ack_hold  = 1'b1;
        nb        = beats.size();
        for (int i = 0; i < 9; i++) begin
            mem_wrreq = 1'b1;
            mem_addr  = 32'h0000_0800 + 32'(i * 4);
            mem_in    = 32'hB000_0000 + 32'(i);
            step();
        end
        mem_wrreq = 1'b0;
        check("ovf err_overflow", {31'd0, err_overflow}, 32'd1);
        ack_delay = 0;
        ack_hold  = 1'b0;
        wait_beats(nb + 8, 50, ok);
        for (int i = 0; i < 5; i++) step();
        check("ovf beat count", beats.size() - nb, 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (beats.size() > nb + i) begin
                check($sformatf("ovf%0d data", i), beats[nb + i].data, 32'hB000_0000 + 32'(i));
            end
        end
        check("ovf err sticky", {31'd0, err_overflow}, 32'd1);

        // Read-after-write ordering
        ack_delay = 1;
        nb        = beats.size();
        mem_wrreq = 1'b1;
        mem_addr  = 32'h0000_0040;
        mem_in    = 32'h1234_5678;
        step();
        mem_wrreq = 1'b0;
        mem_rdreq = 1'b1;
        check("raw write first", {31'd0, bus_we}, 32'd1);
        wait_valid(20, ok, cyc);
        mem_rdreq = 1'b0;
        check("raw valid", {31'd0, ok}, 32'd1);
        check("raw mem_out", mem_out, 32'h1234_5678);
        check("raw beat count", beats.size() - nb, 32'd2);
        if (beats.size() >= nb + 2) begin
            check("raw beat0 we", {31'd0, beats[nb].we}, 32'd1);
            check("raw beat1 we", {31'd0, beats[nb + 1].we}, 32'd0);
            check("raw beat1 addr", beats[nb + 1].addr, 32'h0000_0040);
        end
        step();
        check("raw valid pulse", {31'd0, mem_out_valid}, 32'd0);
        check("raw mem_out hold", mem_out, 32'h1234_5678);

        // Read latency with two wait cycles, then a held request with a new address
        ack_delay = 2;
        mem_rdreq = 1'b1;
        mem_addr  = 32'h0000_0600;
        wait_valid(20, ok, cyc);
        check("lat cycles", 32'(cyc), 32'd4);
        check("lat mem_out", mem_out, 32'hA5A5_A3A5);
        mem_addr = 32'h0000_0604;
        step();
        check("lat2 idle gap", {31'd0, bus_req}, 32'd0);
        step();
        check("lat2 bus_req", {31'd0, bus_req}, 32'd1);
        check("lat2 bus_addr", bus_addr, 32'h0000_0604);
        wait_valid(20, ok, cyc);
        mem_rdreq = 1'b0;
        check("lat2 valid", {31'd0, ok}, 32'd1);
        check("lat2 mem_out", mem_out, 32'hA5A5_A3A1);

        // Collision: the write wins, the read is dropped
        ack_delay = 0;
        step();
        nb        = beats.size();
        mem_rdreq = 1'b1;
        mem_wrreq = 1'b1;
        mem_addr  = 32'h0000_0700;
        mem_in    = 32'hC011_C011;
        step();
        mem_rdreq = 1'b0;
        mem_wrreq = 1'b0;
        check("coll err_collision", {31'd0, err_collision}, 32'd1);
        check("coll bus_addr", bus_addr, 32'h0000_0700);
        step();
        check("coll beat count", beats.size() - nb, 32'd1);
        if (beats.size() > nb) begin
            check("coll beat data", beats[nb].data, 32'hC011_C011);
        end

        // Reset while a read is outstanding
        ack_hold  = 1'b1;
        mem_rdreq = 1'b1;
        mem_addr  = 32'h0000_0704;
        step();
        check("prerst bus_req", {31'd0, bus_req}, 32'd1);
        check("prerst bus_we", {31'd0, bus_we}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst bus_req", {31'd0, bus_req}, 32'd0);
        check("midrst err_overflow", {31'd0, err_overflow}, 32'd0);
        check("midrst err_collision", {31'd0, err_collision}, 32'd0);
        check("midrst mem_out", mem_out, 32'd0);
        mem_rdreq = 1'b0;
        ack_hold  = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        // After reset the FIFO must be empty: a read goes out first at minimum latency
        nb        = beats.size();
        mem_rdreq = 1'b1;
        mem_addr  = 32'h0000_0500;
        wait_valid(20, ok, cyc);
        mem_rdreq = 1'b0;
        check("postrst cycles", 32'(cyc), 32'd2);
        check("postrst mem_out", mem_out, 32'hA5A5_A0A5);
        check("postrst beat count", beats.size() - nb, 32'd1);
        if (beats.size() > nb) begin
            check("postrst beat we", {31'd0, beats[nb].we}, 32'd0);
        end
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
